// File: rtl/ucode_pkg.sv
// Shared constants, field widths and state encoding for the microcode sequencer.
// TRAP state only exists when UCSEQ_ILLEGAL_TRAP_EN is defined.
package ucode_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 20;
  localparam int PAY_W  = 12;
  localparam int CNT_W  = 8;

  localparam logic [3:0] OP_OUT  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'h1;
  localparam logic [3:0] OP_JUMP = 4'h2;
  localparam logic [3:0] OP_WAIT = 4'h4;
  localparam logic [3:0] OP_LOAD = 4'h8;

  localparam logic [3:0] JC_ALWAYS = 4'h0;
  localparam logic [3:0] JC_CNT    = 4'h1;
  localparam logic [3:0] JC_FLAG   = 4'h2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUT_HOLD,
`ifdef UCSEQ_ILLEGAL_TRAP_EN
    S_WAIT,
    S_TRAP
`else
    S_WAIT
`endif
  } state_t;
endpackage

// File: rtl/ucode_decode.sv
// Combinational split of a microcode word into opcode, field A and immediate,
// plus a flag telling whether the opcode is one the sequencer defines.
module ucode_decode
  import ucode_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  output logic [3:0]        opcode_o,
  output logic [3:0]        field_a_o,
  output logic [7:0]        imm_o,
  output logic              legal_o
);
  logic unused_rsvd;

  assign opcode_o    = word_i[15:12];
  assign field_a_o   = word_i[11:8];
  assign imm_o       = word_i[7:0];
  assign unused_rsvd = ^word_i[19:16];

  always_comb begin
    legal_o = 1'b0;
    case (opcode_o)
      OP_OUT, OP_HALT, OP_JUMP, OP_WAIT, OP_LOAD: legal_o = 1'b1;
      default:                                    legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: fetches from a 1-cycle-latency ROM, executes, emits words
// over valid/ready. Optional illegal-opcode trap under UCSEQ_ILLEGAL_TRAP_EN.
module ucode_sequencer
  import ucode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flag_in,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [PAY_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [PAY_W-1:0]  out_q, out_d;
  logic              done_q, done_d;
  logic [3:0]        opcode, field_a;
  logic [7:0]        imm;
  logic              op_legal;

  ucode_decode u_decode (
    .word_i    (rom_data),
    .opcode_o  (opcode),
    .field_a_o (field_a),
    .imm_o     (imm),
    .legal_o   (op_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        // pc advances by default; 6-bit arithmetic gives the 63 -> 0 wrap
        state_d = S_FETCH;
        pc_d    = pc_q + 6'd1;
        case (opcode)
          OP_OUT: begin
            out_d   = rom_data[PAY_W-1:0];
            state_d = S_OUT_HOLD;
          end
          OP_HALT: begin
            state_d = S_IDLE;
            pc_d    = pc_q;
            done_d  = 1'b1;
          end
          OP_JUMP: begin
            case (field_a)
              JC_ALWAYS: pc_d = imm[ADDR_W-1:0];
              JC_CNT: begin
                if (cnt_q != '0) begin
                  cnt_d = cnt_q - 8'd1;
                  pc_d  = imm[ADDR_W-1:0];
                end
              end
              JC_FLAG: if (flag_in) pc_d = imm[ADDR_W-1:0];
              default: ;
            endcase
          end
          OP_WAIT: begin
            if (imm != '0) begin
              state_d = S_WAIT;
              wait_d  = imm;
            end
          end
          OP_LOAD: cnt_d = imm;
          default: begin
`ifdef UCSEQ_ILLEGAL_TRAP_EN
            if (!op_legal) begin
              state_d = S_TRAP;
              pc_d    = pc_q;
            end
`endif
          end
        endcase
      end
      S_OUT_HOLD: if (out_ready) state_d = S_FETCH;
      S_WAIT: begin
        if (wait_q <= 8'd1) state_d = S_FETCH;
        else                wait_d  = wait_q - 8'd1;
      end
`ifdef UCSEQ_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_en    = (state_q == S_FETCH);
  assign rom_addr  = pc_q;
  assign out_data  = out_q;
  assign out_valid = (state_q == S_OUT_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

`ifdef UCSEQ_ILLEGAL_TRAP_EN
  assign err = (state_q == S_TRAP);
`else
  logic unused_legal;
  assign unused_legal = op_legal;
  assign err          = 1'b0;
`endif
endmodule
